dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter in front of the 1024-word data memory, sharing its single read/write port between the CPU load/store unit (port 0) and the debug/DMA loader (port 1). Grants at most one access per cycle, round-robin between ports, drives the memory's address/data/enable lines combinationally in the grant cycle, and returns registered read data plus an out-of-range error one cycle later. Sits between the execute/memory stage and the data memory.

## Interface
- DEPTH, 1024: memory depth in words; word index = addr[31:2].
- LOCK_MAX, 4: maximum consecutive locked grants to one port (used only with DMEM_ARB_LOCK_EN), 1..15.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req0 / req1  in  1  access request, held until granted.
- we0 / we1  in  1  1 = write, 0 = read; stable while req high.
- addr0 / addr1  in  32  byte address; stable while req high.
- wdata0 / wdata1  in  32  write data; stable while req high.
- lock0 / lock1  in  1  keep grant on this port for the next access.
- gnt0 / gnt1  out  1  combinational; access accepted this cycle.
- rvalid0 / rvalid1  out  1  registered; response for previous-cycle grant.
- rdata0 / rdata1  out  32  registered read data (0 for writes and errors).
- err0 / err1  out  1  registered; granted access was out of range; valid with rvalid.
- mem_addr  out  32  to memory addr.
- mem_wdata  out  32  to memory wdata.
- mem_we  out  1  to memory we.
- mem_re  out  1  to memory re.
- mem_rdata  in  32  from memory rdata (combinational read).

## Operation
- Arbitration each cycle: one requester -> grant it; both -> grant port opposite last_gnt; none -> no grant, mem_* enables 0, mem_addr/mem_wdata 0.
- last_gnt register updates only on a grant; reset value 1 (port 0 wins first tie).
- Granted port's addr/wdata routed to mem_addr/mem_wdata; mem_we = we_k & in_range, mem_re = ~we_k & in_range; in_range = addr_k[31:2] < DEPTH.
- Out-of-range grant: no memory enable asserted, still granted, response carries err=1, rdata=0.
- Response register: on grant to k, next cycle rvalid_k=1, rdata_k = read ? mem_rdata captured in grant cycle : 0, err_k = ~in_range. Otherwise rvalid/err 0, rdata holds last value.
- Write completes at the grant-cycle clock edge (memory write); rvalid acks it.
- A port may issue back-to-back requests; with both ports continuously requesting, grants alternate 0,1,0,1.
- While rst_n low: gnt0/gnt1=0 and all mem enables forced 0, so no write occurs in the reset cycle.

## Timing
- Grant latency: 0 cycles (gnt same cycle as req if selected). Response latency: 1 cycle after gnt.
- Throughput: 1 access/cycle total.
- Reset values: rvalid0/1=0, err0/1=0, rdata0/1=0, last_gnt=1, FSM=ARB, lock counter=0.
- Reset asserted mid-operation: pending response dropped (rvalid 0 after the reset edge); requester re-issues.
- Requester must not drop req before gnt; behaviour for dropped req is undefined-free: it simply is not granted.

## Configuration
- DMEM_ARB_LOCK_EN defined: FSM states ARB, LOCK0, LOCK1. Grant to k with lock_k=1 and LOCK_MAX>1 -> LOCKk, counter=1. In LOCKk only port k can be granted; other port waits. Each locked grant increments counter; leave to ARB when a grant has lock_k=0, or when counter reaches LOCK_MAX (that grant is the last locked one), or when req_k low for a cycle. On return to ARB, last_gnt=k, so the other port wins the next tie.
- DMEM_ARB_LOCK_EN undefined: lock0/lock1 ports present but ignored; FSM stays in ARB; pure round-robin.

## Test plan
- Reset then req0 read addr 0x10 (mem[4]=0xDEADBEEF) -> gnt0 same cycle, next cycle rvalid0=1, rdata0=0xDEADBEEF, err0=0.
- req0 and req1 both held for 4 cycles from reset -> grant order 0,1,0,1; rvalid follows one cycle behind each.
- req1 write addr 0x1000 (word 1024) -> gnt1, mem_we=0, next cycle rvalid1=1, err1=1, rdata1=0; memory unchanged.
- req0 write 0x8 data 0x12345678 then read 0x8 back-to-back -> second response rdata0=0x12345678.
- With DMEM_ARB_LOCK_EN, LOCK_MAX=4: lock0=1, req0 and req1 held continuously -> four port-0 grants, then gnt1; without macro -> strict alternation.
- rst_n low in the cycle after a grant -> rvalid stays 0, no mem_we during reset, last_gnt back to 1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single data-memory port between the LSU (port 0) and the debug/DMA loader (port 1).
// Optional burst locking is compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        lock0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  output logic        err0,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  output logic        err1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned WORD_W = 30;
  localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(DEPTH);

  logic        last_gnt;
  logic        sel_valid;
  logic        sel1;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        in_range;

`ifdef DMEM_ARB_LOCK_EN
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LOCK_MAX_W = CNT_W'(LOCK_MAX);
  localparam bit LOCK_OK = (LOCK_MAX > 1);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  state_t           state;
  logic [CNT_W-1:0] lock_cnt;

  // Winner selection: a locked port excludes the other, otherwise round-robin.
  always_comb begin
    sel_valid = 1'b0;
    sel1      = 1'b0;
    if (rst_n) begin
      case (state)
        LOCK0: begin
          sel_valid = req0;
          sel1      = 1'b0;
        end
        LOCK1: begin
          sel_valid = req1;
          sel1      = 1'b1;
        end
        default: begin
          sel_valid = req0 | req1;
          sel1      = (req0 & req1) ? ~last_gnt : req1;
        end
      endcase
    end
  end

  // Lock FSM: enter on a locked grant, leave on unlock, budget exhausted or request gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ARB;
      lock_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (LOCK_OK && gnt0 && lock0) begin
            state    <= LOCK0;
            lock_cnt <= CNT_W'(1);
          end else if (LOCK_OK && gnt1 && lock1) begin
            state    <= LOCK1;
            lock_cnt <= CNT_W'(1);
          end
        end
        LOCK0: begin
          if (!req0 || !lock0 || (lock_cnt + CNT_W'(1) >= LOCK_MAX_W)) begin
            state    <= ARB;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        LOCK1: begin
          if (!req1 || !lock1 || (lock_cnt + CNT_W'(1) >= LOCK_MAX_W)) begin
            state    <= ARB;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= ARB;
          lock_cnt <= '0;
        end
      endcase
    end
  end
`else
  logic unused_lock;
  assign unused_lock = lock0 | lock1;

  // Winner selection: pure round-robin, port 0 wins ties after reset.
  always_comb begin
    sel_valid = 1'b0;
    sel1      = 1'b0;
    if (rst_n) begin
      sel_valid = req0 | req1;
      sel1      = (req0 & req1) ? ~last_gnt : req1;
    end
  end
`endif

  // Route the winner onto the memory port; idle cycles drive zeros.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (sel_valid) begin
      sel_we    = sel1 ? we1    : we0;
      sel_addr  = sel1 ? addr1  : addr0;
      sel_wdata = sel1 ? wdata1 : wdata0;
    end
  end

  assign in_range  = sel_addr[31:2] < DEPTH_W;
  assign gnt0      = sel_valid & ~sel1;
  assign gnt1      = sel_valid &  sel1;
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;
  assign mem_we    = sel_valid &  sel_we & in_range;
  assign mem_re    = sel_valid & ~sel_we & in_range;

  // Response registers and round-robin history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid0  <= 1'b0;
      rdata0   <= '0;
      err0     <= 1'b0;
      rvalid1  <= 1'b0;
      rdata1   <= '0;
      err1     <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      rvalid0 <= gnt0;
      err0    <= gnt0 & ~in_range;
      rvalid1 <= gnt1;
      err1    <= gnt1 & ~in_range;
      if (gnt0) begin
        rdata0 <= mem_re ? mem_rdata : '0;
      end
      if (gnt1) begin
        rdata1 <= mem_re ? mem_rdata : '0;
      end
      if (sel_valid) begin
        last_gnt <= sel1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 1024-word memory.
// Honours DMEM_ARB_LOCK_EN to pick the expected lock-test grant sequence.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, lock0, req1, we1, lock1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  logic [31:0] mem [1024];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(1024), .LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
    .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  // Memory model: combinational read, write at the clock edge.
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic exp_seq [5];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0] = 32'h1111_1111;
    mem[4] = 32'hDEAD_BEEF;
    mem[5] = 32'hCAFE_F00D;
    idle();
    rst_n = 1'b0;

    // Requests during reset are never granted and never reach memory.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h5555_5555;
    req1 = 1'b1;
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_mem4", mem[4], 32'hDEAD_BEEF);
    idle();
    rst_n = 1'b1;

    // Single read from port 0.
    @(negedge clk);
    req0 = 1'b1; addr0 = 32'h10;
    #1;
    chk("rd_gnt0", 32'(gnt0), 32'd1);
    chk("rd_gnt1", 32'(gnt1), 32'd0);
    chk("rd_re", 32'(mem_re), 32'd1);
    chk("rd_addr", mem_addr, 32'h10);
    @(negedge clk);
    idle();
    chk("rd_rvalid0", 32'(rvalid0), 32'd1);
    chk("rd_rdata0", rdata0, 32'hDEAD_BEEF);
    chk("rd_err0", 32'(err0), 32'd0);
    chk("rd_rvalid1", 32'(rvalid1), 32'd0);
    #1;
    chk("idle_addr", mem_addr, 32'd0);

    // Both ports held from reset: strict alternation, responses one cycle behind.
    do_reset();
    req0 = 1'b1; addr0 = 32'h10;
    req1 = 1'b1; addr1 = 32'h14;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("alt_gnt0_%0d", i), 32'(gnt0), 32'((i % 2) == 0));
      chk($sformatf("alt_gnt1_%0d", i), 32'(gnt1), 32'((i % 2) == 1));
      @(negedge clk);
      chk($sformatf("alt_rv0_%0d", i), 32'(rvalid0), 32'((i % 2) == 0));
      chk($sformatf("alt_rv1_%0d", i), 32'(rvalid1), 32'((i % 2) == 1));
      chk($sformatf("alt_rd_%0d", i), (i % 2) == 0 ? rdata0 : rdata1,
          (i % 2) == 0 ? 32'hDEAD_BEEF : 32'hCAFE_F00D);
    end
    idle();

    // Out-of-range write from port 1: granted, no memory write, error response.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h1000; wdata1 = 32'hAAAA_5555;
    #1;
    chk("oor_gnt1", 32'(gnt1), 32'd1);
    chk("oor_we", 32'(mem_we), 32'd0);
    chk("oor_re", 32'(mem_re), 32'd0);
    @(negedge clk);
    idle();
    chk("oor_rvalid1", 32'(rvalid1), 32'd1);
    chk("oor_err1", 32'(err1), 32'd1);
    chk("oor_rdata1", rdata1, 32'd0);
    chk("oor_mem0", mem[0], 32'h1111_1111);

    // Write then read back the same word, back to back.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h1234_5678;
    #1;
    chk("wr_gnt0", 32'(gnt0), 32'd1);
    chk("wr_we", 32'(mem_we), 32'd1);
    chk("wr_wdata", mem_wdata, 32'h1234_5678);
    @(negedge clk);
    we0 = 1'b0;
    chk("wr_rvalid0", 32'(rvalid0), 32'd1);
    chk("wr_err0", 32'(err0), 32'd0);
    chk("wr_rdata0", rdata0, 32'd0);
    #1;
    chk("rb_gnt0", 32'(gnt0), 32'd1);
    chk("rb_re", 32'(mem_re), 32'd1);
    @(negedge clk);
    idle();
    chk("rb_rvalid0", 32'(rvalid0), 32'd1);
    chk("rb_rdata0", rdata0, 32'h1234_5678);

    // Port 0 requests with lock held while port 1 competes.
`ifdef DMEM_ARB_LOCK_EN
    exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
    do_reset();
    req0 = 1'b1; lock0 = 1'b1; addr0 = 32'h10;
    req1 = 1'b1; addr1 = 32'h14;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("lock_gnt0_%0d", i), 32'(gnt0), 32'(!exp_seq[i]));
      chk($sformatf("lock_gnt1_%0d", i), 32'(gnt1), 32'(exp_seq[i]));
      @(negedge clk);
    end
    idle();

    // Reset in the cycle after a grant drops the response and restores port-0 priority.
    @(negedge clk);
    req0 = 1'b1; addr0 = 32'h10;
    #1;
    chk("mr_gnt0", 32'(gnt0), 32'd1);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h14; wdata1 = 32'h0BAD_0BAD;
    #1;
    chk("mr_gnt1", 32'(gnt1), 32'd0);
    chk("mr_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("mr_rvalid0", 32'(rvalid0), 32'd0);
    chk("mr_rdata0", rdata0, 32'd0);
    chk("mr_mem5", mem[5], 32'hCAFE_F00D);
    rst_n = 1'b1;
    we1 = 1'b0;
    req0 = 1'b1; addr0 = 32'h10;
    #1;
    chk("mr_tie_gnt0", 32'(gnt0), 32'd1);
    chk("mr_tie_gnt1", 32'(gnt1), 32'd0);
    @(negedge clk);
    idle();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
